// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute control sequencer for the KGP_RISC front end.
// Optional link register enabled by defining KGP_FETCH_LINK_REG_EN.
module fetch_sequencer #(
  parameter int PC_W    = 10,
  parameter int MEM_LAT = 2,
  parameter int RST_PC  = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            halt_req,
  output logic            imem_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  output logic [31:0]     instr_q,
  output logic            instr_valid,
  input  logic            ex_done,
  input  logic            br_take,
  input  logic [PC_W-1:0] br_target,
  input  logic            flag_we,
  input  logic [3:0]      flags_in,
  output logic [3:0]      flags,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] npc,
  output logic            busy,
  input  logic            link_we,
  output logic [31:0]     ra
);

  // state  | meaning
  // IDLE   | stopped, waiting for run
  // FETCH  | memory read issued at pc
  // WAIT   | counting down the memory read latency
  // DECODE | instr_q presented to decode for one cycle
  // EXEC   | waiting for ex_done, then pc update
  // HALT   | stopped by halt_req, re-armed by run=0
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    DECODE = 3'd3,
    EXEC   = 3'd4,
    HALT   = 3'd5
  } stateT;

  localparam logic [2:0] WAIT_LOAD = 3'(MEM_LAT - 1);

  stateT      state, stateNext;
  logic [2:0] waitCnt;
  logic       exDoneFire;

  assign exDoneFire  = (state == EXEC) && ex_done;
  assign npc         = pc + PC_W'(1);
  assign imem_addr   = pc;
  assign imem_en     = (state == FETCH);
  assign instr_valid = (state == DECODE);
  assign busy        = (state == FETCH) || (state == WAIT) ||
                       (state == DECODE) || (state == EXEC);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:   if (run) stateNext = FETCH;
      FETCH:  stateNext = WAIT;
      WAIT:   if (waitCnt == 3'd0) stateNext = DECODE;
      DECODE: stateNext = EXEC;
      EXEC: begin
        if (ex_done) begin
          if (halt_req)  stateNext = HALT;
          else if (!run) stateNext = IDLE;
          else           stateNext = FETCH;
        end
      end
      HALT:   if (!run) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Down-counter reaches zero on the cycle the read data becomes valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt <= 3'd0;
    end else if (state == FETCH) begin
      waitCnt <= WAIT_LOAD;
    end else if ((state == WAIT) && (waitCnt != 3'd0)) begin
      waitCnt <= waitCnt - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= 32'd0;
      pc      <= PC_W'(RST_PC);
      flags   <= 4'd0;
    end else begin
      if ((state == WAIT) && (waitCnt == 3'd0)) instr_q <= imem_data;
      if (exDoneFire) pc <= br_take ? br_target : npc;
      if ((state == EXEC) && flag_we) flags <= flags_in;
    end
  end

`ifdef KGP_FETCH_LINK_REG_EN
  logic [31:0] raQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 raQ <= 32'd0;
    else if (exDoneFire && br_take && link_we)  raQ <= 32'(npc);
  end

  assign ra = raQ;
`else
  logic unusedLinkWe;

  assign unusedLinkWe = link_we;
  assign ra           = 32'd0;
`endif

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Multi-cycle control sequencer for the KGP_RISC front end.
- Drives instruction-memory fetch (block RAM with fixed read latency) and hands each fetched word to decode.
- Waits for execute completion, then selects next PC: branch target when the branch unit asserts PCSrc, else PC+1.
- Holds the architectural flag register (carry, zero, overflow, sign) consumed by the branch unit.

Parameters:
- PC_W, 10, PC / instruction-memory address width.
- MEM_LAT, 2, instruction-memory read latency in cycles (legal range 1..7).
- RST_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  enables sequencing.
- halt_req  in  1  stop after current instruction.
- imem_en  out  1  instruction-memory read enable.
- imem_addr  out  PC_W  instruction-memory address.
- imem_data  in  32  instruction-memory read data.
- instr_q  out  32  latched instruction.
- instr_valid  out  1  one-cycle pulse: instr_q valid for decode.
- ex_done  in  1  datapath finished executing instr_q.
- br_take  in  1  PCSrc from branch unit.
- br_target  in  PC_W  branch target from branch unit.
- flag_we  in  1  flag register write enable.
- flags_in  in  4  {c,z,o,s} from ALU.
- flags  out  4  registered {c,z,o,s}.
- pc  out  PC_W  PC of current instruction.
- npc  out  PC_W  pc+1, modulo 2^PC_W, combinational.
- busy  out  1  high in FETCH, WAIT, DECODE, EXEC.
- link_we  in  1  call-with-link request (used only with LINK_REG_EN).
- ra  out  32  link register.

Behaviour:
- Reset (async, rst_n=0) forces, immediately and independent of clk:
  - state=IDLE, pc=RST_PC, instr_q=0, flags=0, ra=0, wait counter=0.
  - imem_en=0, instr_valid=0, busy=0.
  - Reset asserted mid-fetch or mid-execute abandons the instruction; no flag or PC update occurs.
- FSM state encoding: IDLE=0, FETCH=1, WAIT=2, DECODE=3, EXEC=4, HALT=5.
- IDLE: imem_en=0. Go to FETCH when run=1.
- FETCH (1 cycle): imem_en=1, imem_addr=pc; load counter with MEM_LAT-1; go to WAIT.
- WAIT: imem_en=0; counter decrements each cycle. At counter==0, instr_q<=imem_data and go to DECODE. Total FETCH-to-latch latency is MEM_LAT+1 cycles.
- DECODE (1 cycle): instr_valid=1; go to EXEC.
- EXEC: hold until ex_done=1.
  - On ex_done, pc <= br_take ? br_target : pc+1, wrapping modulo 2^PC_W.
  - Next state priority: halt_req=1 -> HALT; else run=0 -> IDLE; else FETCH.
  - br_take, br_target and halt_req are sampled only on the ex_done cycle and ignored otherwise.
- Flags: flags<=flags_in on any EXEC cycle with flag_we=1, including the ex_done cycle. flag_we in any other state is ignored.
- HALT: imem_en=0, busy=0; pc holds. Leave to IDLE only when run=0 (re-arm); remain in HALT while run=1.
- imem_addr equals pc in every state; imem_en is the only qualifier.
- Minimum throughput: MEM_LAT+3 cycles per instruction when ex_done is asserted in the first EXEC cycle.
- Unused state encodings (6, 7) transition to IDLE on the next clock.

Optional Feature:
- Macro: KGP_FETCH_LINK_REG_EN.
- Defined: on ex_done with br_take=1 and link_we=1, ra <= zero-extended (pc+1) modulo 2^PC_W. Plain taken branches (link_we=0) leave ra unchanged.
- Undefined: ra is tied to 32'd0 and link_we is ignored. Port list is identical in both builds.

Test Plan:
1. Straight-line run, MEM_LAT=2: reset, run=1, imem_data=pc-dependent pattern, ex_done one cycle after each instr_valid, no branch -> imem_en pulses at addr 0,1,2 spaced 5 cycles apart; instr_q matches each word; instr_valid is one cycle wide.
2. Taken branch: pc=120, br_take=1, br_target=150 on ex_done -> next FETCH imem_addr=150. Then br_take=1 held during EXEC but dropped before ex_done -> pc=151 (not taken).
3. Wrap-around: pc=1023, ex_done with br_take=0 -> pc=0, npc=1.
4. Flags: flag_we=1, flags_in=4'b1011 in EXEC -> flags=1011 next cycle. flag_we=1, flags_in=0000 in IDLE -> flags stay 1011. flag_we with ex_done in the same cycle -> update applied.
5. Halt and resume: halt_req=1 with ex_done at pc=5 -> HALT, busy=0, no imem_en with run=1. run=0 -> IDLE, pc=6. run=1 -> fetch at 6. Separately, rst_n=0 mid-WAIT -> all outputs reset without a clock edge; pc=RST_PC.
6. KGP_FETCH_LINK_REG_EN defined: pc=120, br_take=1, link_we=1, br_target=150 -> ra=121, pc=150. Same stimulus with macro undefined -> ra=0.
